// File: rtl/joyirq_service_master.sv
// joyirq_service_master
// Services the joystick edge-capture PIO without a CPU: unmasks its
// interrupt after reset, answers each pio_irq with a data read followed by
// an edge-capture clear, and queues {pin level, timestamp} events into a
// show-ahead FIFO.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   pio_address/..._n     Avalon-MM master drive towards the PIO slave
//   pio_readdata          PIO read data, valid one cycle after the read
//   pio_irq               PIO level interrupt
//   enable                gates the start of new service sequences
//   evt_valid/data/ready  event FIFO head, popped on valid & ready
//   overflow, overflow_clr sticky dropped-event flag and its clear
module joyirq_service_master #(
   parameter int TS_WIDTH   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic [1:0]          pio_address,
   output logic                pio_chipselect,
   output logic                pio_write_n,
   output logic [31:0]         pio_writedata,
   input  logic [31:0]         pio_readdata,
   input  logic                pio_irq,
   input  logic                enable,
   output logic                evt_valid,
   output logic [TS_WIDTH:0]   evt_data,
   input  logic                evt_ready,
   output logic                overflow,
   input  logic                overflow_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_INIT, S_WAIT, S_READ, S_CLEAR} state_t;

   state_t              state_q, state_d;
   logic [TS_WIDTH-1:0] cnt_q;
   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [TS_WIDTH:0]   mem_q [FIFO_DEPTH];
   logic [AW:0]         wr_ptr_q, rd_ptr_q;
   logic                overflow_q, overflow_d;
   logic                empty, full, push, pop, push_ok;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_INIT;
      else          state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:  state_d = S_WAIT;
         S_WAIT:  if (pio_irq && enable) state_d = S_READ;
         S_READ:  state_d = S_CLEAR;
         S_CLEAR: state_d = S_WAIT;
         default: state_d = S_INIT;
      endcase
   end

   // ---------------- FSM: bus outputs ----------------
   // Gated by reset_n so the bus is idle while reset is held, yet the INIT
   // write appears in the very first cycle after release.
   always_comb begin
      pio_chipselect = 1'b0;
      pio_write_n    = 1'b1;
      pio_address    = 2'd0;
      pio_writedata  = 32'd0;
      if (reset_n) begin
         case (state_q)
            S_INIT: begin
               pio_chipselect = 1'b1;
               pio_write_n    = 1'b0;
               pio_address    = 2'd2;
               pio_writedata  = 32'd1;
            end
            S_READ: begin
               pio_chipselect = 1'b1;
               pio_address    = 2'd0;
            end
            S_CLEAR: begin
               pio_chipselect = 1'b1;
               pio_write_n    = 1'b0;
               pio_address    = 2'd3;
               pio_writedata  = 32'd1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- timestamp ----------------
   always_comb begin
      ts_d = ts_q;
      if (state_q == S_WAIT && pio_irq && enable) ts_d = cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         ts_q  <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
         ts_q  <= ts_d;
      end
   end

   // ---------------- event FIFO ----------------
   // Read data arrives in CLEAR, so that is the push cycle.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push    = (state_q == S_CLEAR);
   assign pop     = !empty && evt_ready;
   // A simultaneous pop frees the head slot, which the push then reuses.
   assign push_ok = push && (!full || pop);

   assign evt_valid = !empty;
   assign evt_data  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {pio_readdata[0], ts_q};
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // ---------------- overflow ----------------
   always_comb begin
      overflow_d = overflow_q;
      if (overflow_clr)             overflow_d = 1'b0;
      if (push && full && !pop)     overflow_d = 1'b1;  // set beats clear
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) overflow_q <= 1'b0;
      else          overflow_q <= overflow_d;
   end

   assign overflow = overflow_q;

endmodule

// File: tb/tb_joyirq_service_master.sv
module tb_joyirq_service_master;

   localparam logic [35:0] B_IDLE  = {1'b0, 1'b1, 2'd0, 32'd0};
   localparam logic [35:0] B_INIT  = {1'b1, 1'b0, 2'd2, 32'd1};
   localparam logic [35:0] B_READ  = {1'b1, 1'b1, 2'd0, 32'd0};
   localparam logic [35:0] B_CLEAR = {1'b1, 1'b0, 2'd3, 32'd1};

   logic        clk = 1'b0;
   logic        reset_n, enable, evt_ready, overflow_clr;
   logic [1:0]  pio_address;
   logic        pio_chipselect, pio_write_n, pio_irq;
   logic [31:0] pio_writedata, pio_readdata;
   logic        evt_valid, overflow;
   logic [16:0] evt_data;

   // second instance, narrow timestamp, irq driven directly
   logic [1:0]  p4_address;
   logic        p4_cs, p4_wn, irq4, ready4, ev4_valid, ov4;
   logic [31:0] p4_wd;
   logic [4:0]  ev4_data;

   // PIO model
   logic pin, pin_prev, cap, mask;

   int cyc;
   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   joyirq_service_master u_dut (
      .clk(clk), .reset_n(reset_n),
      .pio_address(pio_address), .pio_chipselect(pio_chipselect),
      .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
      .pio_readdata(pio_readdata), .pio_irq(pio_irq), .enable(enable),
      .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
      .overflow(overflow), .overflow_clr(overflow_clr)
   );

   joyirq_service_master #(.TS_WIDTH(4), .FIFO_DEPTH(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n),
      .pio_address(p4_address), .pio_chipselect(p4_cs),
      .pio_write_n(p4_wn), .pio_writedata(p4_wd),
      .pio_readdata(32'h1), .pio_irq(irq4), .enable(1'b1),
      .evt_valid(ev4_valid), .evt_data(ev4_data), .evt_ready(ready4),
      .overflow(ov4), .overflow_clr(1'b0)
   );

   always @(posedge clk or negedge reset_n)
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;

   // edge-capture PIO: clear write beats a coincident edge
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask <= 1'b0; cap <= 1'b0; pin_prev <= 1'b0; pio_readdata <= '0;
      end else begin
         if (pio_chipselect && !pio_write_n && pio_address == 2'd2) mask <= pio_writedata[0];
         if (pio_chipselect && !pio_write_n && pio_address == 2'd3 && pio_writedata[0]) cap <= 1'b0;
         else if (pin != pin_prev) cap <= 1'b1;
         pin_prev <= pin;
         pio_readdata <= (pio_chipselect && pio_write_n && pio_address == 2'd0) ? {31'd0, pin} : 32'd0;
      end
   end
   assign pio_irq = mask & cap;

   function automatic logic [35:0] bus();
      return {pio_chipselect, pio_write_n, pio_address, pio_writedata};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pop1();
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   // Raise an edge so the pin reads new_pin, follow the service sequence,
   // and return the event the bench expects.
   task automatic do_event(input logic new_pin, input logic pop_clr, output logic [16:0] exp);
      logic found;
      int   n;
      @(negedge clk);
      if (pin == new_pin) begin
         pin = ~new_pin;
         @(negedge clk);
      end
      pin = new_pin;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (pio_irq) begin found = 1'b1; break; end
         @(negedge clk);
      end
      chk("irq_seen", found, 1);
      n   = cyc;
      exp = {new_pin, n[15:0]};
      @(negedge clk); chk("read_bus", bus(), B_READ);
      @(negedge clk); chk("clear_bus", bus(), B_CLEAR);
      if (pop_clr) evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      chk("done_bus", bus(), B_IDLE);
      chk("irq_low", pio_irq, 0);
      chk("evt_valid", evt_valid, 1);
   endtask

   logic [16:0] e [5];
   logic [16:0] ex;
   int          n0;
   logic        hit;

   initial begin
      reset_n = 1'b0; enable = 1'b1; evt_ready = 1'b0; overflow_clr = 1'b0;
      pin = 1'b0; irq4 = 1'b0; ready4 = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_bus", bus(), B_IDLE);
      chk("rst_valid", evt_valid, 0);
      chk("rst_data", evt_data, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst4_valid", ev4_valid, 0);
      reset_n = 1'b1;
      #1 chk("init_bus", bus(), B_INIT);
      chk("init4_cs", p4_cs, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_bus", bus(), B_IDLE);
         chk("idle_valid", evt_valid, 0);
      end

      // single edges, pin 0 then pin 1
      do_event(1'b0, 1'b0, e[0]);
      chk("ev0_data", evt_data, e[0]);
      chk("ev0_pin", evt_data[16], 0);
      do_event(1'b1, 1'b0, e[1]);
      chk("ev1_head", evt_data, e[0]);
      pop1();
      chk("ev1_data", evt_data, e[1]);
      pop1();
      chk("ev_empty", evt_valid, 0);

      // enable gating
      enable = 1'b0;
      @(negedge clk); pin = ~pin;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("en_idle", pio_chipselect, 0);
      end
      chk("en_irq", pio_irq, 1);
      enable = 1'b1;
      n0 = cyc;
      @(negedge clk); chk("en_read", bus(), B_READ);
      enable = 1'b0;
      @(negedge clk); chk("en_clear", bus(), B_CLEAR);
      @(negedge clk);
      ex = {pin, n0[15:0]};
      chk("en_data", evt_data, ex);
      chk("en_valid", evt_valid, 1);
      enable = 1'b1;
      pop1();

      // overflow: 5 pushes, no pops
      for (int i = 0; i < 5; i++) begin
         do_event(~pin, 1'b0, e[i]);
         if (i == 3) chk("ovf_at4", overflow, 0);
      end
      chk("ovf_set", overflow, 1);
      @(negedge clk); overflow_clr = 1'b1;
      @(negedge clk); overflow_clr = 1'b0;
      chk("ovf_clr", overflow, 0);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_order", evt_data, e[i]);
         pop1();
      end
      chk("ovf_empty", evt_valid, 0);

      // full with coincident pop: push accepted
      for (int i = 0; i < 4; i++) do_event(~pin, 1'b0, e[i]);
      do_event(~pin, 1'b1, e[4]);
      chk("fp_ovf", overflow, 0);
      for (int i = 1; i < 5; i++) begin
         chk("fp_order", evt_data, e[i]);
         pop1();
      end
      chk("fp_empty", evt_valid, 0);

      // timestamp wrap on the 4-bit instance
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (cyc % 16 == 14) begin hit = 1'b1; break; end
         @(negedge clk);
      end
      chk("wrap_sync", hit, 1);
      irq4 = 1'b1;
      @(negedge clk); chk("wrap_read", p4_cs & p4_wn, 1);
      @(negedge clk);
      @(negedge clk);
      chk("wrap_v1", ev4_valid, 1);
      chk("wrap_d1", ev4_data, 5'b1_1110);
      @(negedge clk); chk("wrap_read2", p4_cs & p4_wn, 1);
      irq4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("wrap_head", ev4_data, 5'b1_1110);
      ready4 = 1'b1; @(negedge clk); ready4 = 1'b0;
      chk("wrap_d2", ev4_data, 5'b1_0001);
      ready4 = 1'b1; @(negedge clk); ready4 = 1'b0;
      chk("wrap_empty", ev4_valid, 0);

      // reset in the middle of a sequence
      do_event(~pin, 1'b0, e[0]);
      @(negedge clk); pin = ~pin;
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (pio_chipselect) begin hit = 1'b1; break; end
      end
      chk("mid_read", bus(), B_READ);
      #1 reset_n = 1'b0;
      #1 chk("mid_bus", bus(), B_IDLE);
      chk("mid_valid", evt_valid, 0);
      chk("mid_data", evt_data, 0);
      pin = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("mid_init", bus(), B_INIT);
      @(negedge clk); chk("mid_idle", bus(), B_IDLE);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
